// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues word loads/stores over a req/ack handshake,
// stalls upstream while an access is in flight, and registers the writeback bundle.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        rd_write_enable_in,
    input  logic [4:0]  rd_write_addr_in,
    input  logic        res_src_in,
    input  logic        mem_write_enable_in,
    input  logic [31:0] exec_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [31:0] next_pc_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        rd_write_enable_out,
    output logic [4:0]  rd_write_addr_out,
    output logic [31:0] wb_data_out,
    output logic [31:0] next_pc_out,
    output logic        err_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic        r_abort;
    logic        r_rd_we;
    logic [4:0]  r_rd_addr;
    logic        r_is_store;
    logic [31:0] r_exec;
    logic [31:0] r_wdata;
    logic [31:0] r_next_pc;
    logic [31:0] r_rdata;

    logic w_mem_op;
    logic w_misaligned;
    logic w_timeout;

    assign w_mem_op     = valid_in & (res_src_in | mem_write_enable_in);
    assign w_misaligned = (exec_in[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_mem_op && !w_misaligned) w_state_nxt = S_ACCESS;
            S_ACCESS: if (dmem_ack || w_timeout) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are gated by state so they read 0 outside an access.
    always_comb begin
        stall_out  = (r_state != S_IDLE);
        dmem_req   = (r_state == S_ACCESS);
        dmem_we    = dmem_req & r_is_store;
        dmem_addr  = dmem_req ? {r_exec[31:2], 2'b00} : 32'd0;
        dmem_wdata = dmem_req ? r_wdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt               <= '0;
            r_abort             <= 1'b0;
            wb_valid            <= 1'b0;
            err_out             <= 1'b0;
            rd_write_enable_out <= 1'b0;
            rd_write_addr_out   <= 5'd0;
            wb_data_out         <= 32'd0;
            next_pc_out         <= 32'd0;
        end else begin
            wb_valid <= 1'b0;
            err_out  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        wb_valid          <= 1'b1;
                        rd_write_addr_out <= rd_write_addr_in;
                        next_pc_out       <= next_pc_in;
                        wb_data_out       <= exec_in;
                        if (w_mem_op && w_misaligned) begin
                            rd_write_enable_out <= 1'b0;
                            err_out             <= 1'b1;
                        end else if (w_mem_op) begin
                            // Aligned access: bundle is held until DONE emits it.
                            wb_valid   <= 1'b0;
                            r_rd_we    <= rd_write_enable_in;
                            r_rd_addr  <= rd_write_addr_in;
                            r_is_store <= mem_write_enable_in;
                            r_exec     <= exec_in;
                            r_wdata    <= mem_write_data_in;
                            r_next_pc  <= next_pc_in;
                            r_cnt      <= '0;
                            r_abort    <= 1'b0;
                        end else begin
                            rd_write_enable_out <= rd_write_enable_in;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        if (!r_is_store) r_rdata <= dmem_rdata;
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    wb_valid            <= 1'b1;
                    rd_write_addr_out   <= r_rd_addr;
                    next_pc_out         <= r_next_pc;
                    wb_data_out         <= (!r_is_store && !r_abort) ? r_rdata : r_exec;
                    rd_write_enable_out <= r_rd_we & ~r_abort;
                    err_out             <= r_abort;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU passthrough, load/store handshakes,
// misalignment, timeout and reset during an access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        rd_write_enable_in;
    logic [4:0]  rd_write_addr_in;
    logic        res_src_in;
    logic        mem_write_enable_in;
    logic [31:0] exec_in;
    logic [31:0] mem_write_data_in;
    logic [31:0] next_pc_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        rd_write_enable_out;
    logic [4:0]  rd_write_addr_out;
    logic [31:0] wb_data_out;
    logic [31:0] next_pc_out;
    logic        err_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_in            (valid_in),
        .rd_write_enable_in  (rd_write_enable_in),
        .rd_write_addr_in    (rd_write_addr_in),
        .res_src_in          (res_src_in),
        .mem_write_enable_in (mem_write_enable_in),
        .exec_in             (exec_in),
        .mem_write_data_in   (mem_write_data_in),
        .next_pc_in          (next_pc_in),
        .stall_out           (stall_out),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .wb_valid            (wb_valid),
        .rd_write_enable_out (rd_write_enable_out),
        .rd_write_addr_out   (rd_write_addr_out),
        .wb_data_out         (wb_data_out),
        .next_pc_out         (next_pc_out),
        .err_out             (err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rs, input logic mw, input logic rwe,
                         input logic [4:0] rd, input logic [31:0] ex,
                         input logic [31:0] wd, input logic [31:0] pc);
        valid_in            = v;
        res_src_in          = rs;
        mem_write_enable_in = mw;
        rd_write_enable_in  = rwe;
        rd_write_addr_in    = rd;
        exec_in             = ex;
        mem_write_data_in   = wd;
        next_pc_in          = pc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wb_valid"}, {31'd0, wb_valid}, 32'd0);
        check({tag, ".req"},      {31'd0, dmem_req}, 32'd0);
        check({tag, ".stall"},    {31'd0, stall_out}, 32'd0);
        check({tag, ".err"},      {31'd0, err_out}, 32'd0);
        check({tag, ".rd_we"},    {31'd0, rd_write_enable_out}, 32'd0);
        check({tag, ".rd_addr"},  {27'd0, rd_write_addr_out}, 32'd0);
        check({tag, ".wb_data"},  wb_data_out, 32'd0);
        check({tag, ".next_pc"},  next_pc_out, 32'd0);
        check({tag, ".addr"},     dmem_addr, 32'd0);
        check({tag, ".wdata"},    dmem_wdata, 32'd0);
    endtask

    int n;

    initial begin
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: ALU passthrough
        drive(1, 0, 0, 1, 5'd5, 32'h3, 32'd0, 32'h104);
        check("alu.stall0", {31'd0, stall_out}, 32'd0);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("alu.wb_valid", {31'd0, wb_valid}, 32'd1);
        check("alu.data",     wb_data_out, 32'h3);
        check("alu.rd",       {27'd0, rd_write_addr_out}, 32'd5);
        check("alu.rd_we",    {31'd0, rd_write_enable_out}, 32'd1);
        check("alu.pc",       next_pc_out, 32'h104);
        check("alu.stall1",   {31'd0, stall_out}, 32'd0);
        step();
        check("alu.wb_drop",  {31'd0, wb_valid}, 32'd0);

        // 2: load, ack on third ACCESS cycle
        drive(1, 1, 0, 1, 5'd7, 32'h10, 32'd0, 32'h200);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ld.req",   {31'd0, dmem_req}, 32'd1);
            check("ld.we",    {31'd0, dmem_we}, 32'd0);
            check("ld.addr",  dmem_addr, 32'h10);
            check("ld.stall", {31'd0, stall_out}, 32'd1);
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'd0;
        end
        check("ld.done_req",   {31'd0, dmem_req}, 32'd0);
        check("ld.done_stall", {31'd0, stall_out}, 32'd1);
        check("ld.done_wb",    {31'd0, wb_valid}, 32'd0);
        step();
        check("ld.wb_valid", {31'd0, wb_valid}, 32'd1);
        check("ld.data",     wb_data_out, 32'hDEADBEEF);
        check("ld.rd",       {27'd0, rd_write_addr_out}, 32'd7);
        check("ld.rd_we",    {31'd0, rd_write_enable_out}, 32'd1);
        check("ld.pc",       next_pc_out, 32'h200);
        check("ld.stall",    {31'd0, stall_out}, 32'd0);
        check("ld.err",      {31'd0, err_out}, 32'd0);

        // 3: store, zero-wait ack
        drive(1, 0, 1, 1, 5'd3, 32'h20, 32'hCAFEF00D, 32'h300);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("st.req",   {31'd0, dmem_req}, 32'd1);
        check("st.we",    {31'd0, dmem_we}, 32'd1);
        check("st.addr",  dmem_addr, 32'h20);
        check("st.wdata", dmem_wdata, 32'hCAFEF00D);
        check("st.wb1",   {31'd0, wb_valid}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check("st.req_drop", {31'd0, dmem_req}, 32'd0);
        check("st.wb2",      {31'd0, wb_valid}, 32'd0);
        step();
        check("st.wb3",   {31'd0, wb_valid}, 32'd1);
        check("st.data",  wb_data_out, 32'h20);
        check("st.rd_we", {31'd0, rd_write_enable_out}, 32'd1);
        check("st.pc",    next_pc_out, 32'h300);

        // 4: misaligned load
        drive(1, 1, 0, 1, 5'd4, 32'h12, 32'd0, 32'h400);
        check("mis.req0", {31'd0, dmem_req}, 32'd0);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("mis.req1",  {31'd0, dmem_req}, 32'd0);
        check("mis.err",   {31'd0, err_out}, 32'd1);
        check("mis.wb",    {31'd0, wb_valid}, 32'd1);
        check("mis.rd_we", {31'd0, rd_write_enable_out}, 32'd0);
        check("mis.stall", {31'd0, stall_out}, 32'd0);
        step();
        check("mis.err_drop", {31'd0, err_out}, 32'd0);

        // 5: timeout, ack never arrives
        drive(1, 1, 0, 1, 5'd6, 32'h40, 32'd0, 32'h500);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            step();
        end
        check("to.req_cycles", n, 32'd16);
        check("to.done_stall", {31'd0, stall_out}, 32'd1);
        check("to.done_wb",    {31'd0, wb_valid}, 32'd0);
        step();
        check("to.err",   {31'd0, err_out}, 32'd1);
        check("to.wb",    {31'd0, wb_valid}, 32'd1);
        check("to.rd_we", {31'd0, rd_write_enable_out}, 32'd0);
        check("to.stall", {31'd0, stall_out}, 32'd0);
        step();
        check("to.err_drop", {31'd0, err_out}, 32'd0);

        // 6: reset during ACCESS, late ack ignored
        drive(1, 1, 0, 1, 5'd8, 32'h80, 32'd0, 32'h600);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        step();
        check("rst.req_before", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAADF00D;
        check_all_zero("rst");
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        check("rst.late_wb",  {31'd0, wb_valid}, 32'd0);
        check("rst.late_req", {31'd0, dmem_req}, 32'd0);
        drive(1, 0, 0, 1, 5'd9, 32'h55, 32'd0, 32'h700);
        step();
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        check("post.wb",   {31'd0, wb_valid}, 32'd1);
        check("post.data", wb_data_out, 32'h55);
        check("post.rd",   {27'd0, rd_write_addr_out}, 32'd9);
        check("post.pc",   next_pc_out, 32'h700);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
